// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared FSM state type for the multi-cycle subtractor
package sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// rtl/full_subtractor_1bit.sv - one-bit full subtractor cell (a - b - bin)
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/multicycle_subtractor.sv
// rtl/multicycle_subtractor.sv - CHUNK-bits-per-cycle subtractor with registered borrow chain
// Optional signed-overflow output ovf enabled by defining SUB_OVF_EN.
`ifndef W_COE
`define W_COE 8
`endif
module multicycle_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = `W_COE,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic [CHUNK-1:0] a_chunk, b_chunk, d_chunk;
    logic [CHUNK:0]   chain;
    logic             accept, last;

    assign accept  = in_valid && (state == S_IDLE);
    assign last    = (cnt_q == LAST);
    assign a_chunk = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign b_chunk = b_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign chain[0] = borrow_q;

    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        full_subtractor_1bit u_cell (
            .a    (a_chunk[i]),
            .b    (b_chunk[i]),
            .bin  (chain[i]),
            .d    (d_chunk[i]),
            .bout (chain[i+1])
        );
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_RUN;
            end
            S_RUN: begin
                if (last) state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Result bits land in diff as each chunk resolves; bout/ovf only on the final chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff     <= '0;
            bout     <= 1'b0;
`ifdef SUB_OVF_EN
            ovf      <= 1'b0;
`endif
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
        end else if (state == S_RUN) begin
            diff[int'(cnt_q)*CHUNK +: CHUNK] <= d_chunk;
            borrow_q <= chain[CHUNK];
            cnt_q    <= cnt_q + CW'(1);
            if (last) begin
                bout <= chain[CHUNK];
`ifdef SUB_OVF_EN
                ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_chunk[CHUNK-1] != a_q[WIDTH-1]);
`endif
            end
        end
    end

endmodule
